// File: rtl/mp_adder_limb_seq_if.sv
// Operand/result handshake bundle for the limb-serial multi-precision adder.
interface mp_adder_limb_seq_if #(
  parameter int ADDER_WIDTH = 256
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDER_WIDTH-1:0] in_a;
  logic [ADDER_WIDTH-1:0] in_b;
  logic                   in_c;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDER_WIDTH-1:0] out_sum;
  logic                   out_c;
  logic                   busy;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_c, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_c, busy
  );
endinterface

// File: rtl/mp_adder_limb_seq.sv
// Limb-serial wide adder: one 16-bit limb per cycle, LSB first, producing per-bit
// G/P for a 16-bit carry-lookahead stage and sequencing the carry between limbs.
module mp_adder_limb_seq #(
  parameter int ADDER_WIDTH = 256,
  parameter int LIMB_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mp_adder_limb_seq_if.slave    bus
);
  localparam int NUM_LIMBS = ADDER_WIDTH / LIMB_WIDTH;
  localparam int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  generate
    if (LIMB_WIDTH != 16) begin : g_bad_limb
      $error("mp_adder_limb_seq: LIMB_WIDTH must be 16");
    end
    if (ADDER_WIDTH < 16 || (ADDER_WIDTH % 16) != 0) begin : g_bad_width
      $error("mp_adder_limb_seq: ADDER_WIDTH must be a positive multiple of 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [ADDER_WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic                   carry_reg, out_c_reg;
  logic [IDX_W-1:0]       idx_reg;

  logic [LIMB_WIDTH-1:0]  a_limbs [NUM_LIMBS];
  logic [LIMB_WIDTH-1:0]  b_limbs [NUM_LIMBS];
  logic [LIMB_WIDTH-1:0]  a_limb, b_limb, g, p, limb_sum;
  logic [LIMB_WIDTH:0]    ripple;
  logic                   cla_cout, last_limb;

  // Two-level lookahead: 4-bit group G/P, then a group-level carry.
  function automatic logic cla16(input logic [15:0] gv, input logic [15:0] pv, input logic cin);
    logic [3:0] gg, pg;
    for (int j = 0; j < 4; j++) begin
      gg[j] = gv[4*j+3]
            | (pv[4*j+3] & gv[4*j+2])
            | (pv[4*j+3] & pv[4*j+2] & gv[4*j+1])
            | (pv[4*j+3] & pv[4*j+2] & pv[4*j+1] & gv[4*j]);
      pg[j] = &pv[4*j +: 4];
    end
    return gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
         | (pg[3] & pg[2] & pg[1] & gg[0]) | ((&pg) & cin);
  endfunction

  for (genvar gi = 0; gi < NUM_LIMBS; gi++) begin : g_limb
    assign a_limbs[gi] = a_reg[gi*LIMB_WIDTH +: LIMB_WIDTH];
    assign b_limbs[gi] = b_reg[gi*LIMB_WIDTH +: LIMB_WIDTH];
  end

  assign a_limb    = a_limbs[idx_reg];
  assign b_limb    = b_limbs[idx_reg];
  assign g         = a_limb & b_limb;
  assign p         = a_limb ^ b_limb;
  assign last_limb = (idx_reg == IDX_W'(NUM_LIMBS - 1));
  assign cla_cout  = cla16(g, p, carry_reg);

  // Bit-level carry chain forms the sum bits; its final carry cross-checks the lookahead.
  always_comb begin
    ripple    = '0;
    ripple[0] = carry_reg;
    for (int i = 0; i < LIMB_WIDTH; i++) begin
      ripple[i+1] = g[i] | (p[i] & ripple[i]);
    end
    limb_sum = p ^ ripple[LIMB_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_limb)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.busy      = (state_reg == RUN);
    bus.out_valid = (state_reg == DONE);
    bus.out_sum   = sum_reg;
    bus.out_c     = out_c_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      out_c_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.in_valid) begin
          a_reg     <= bus.in_a;
          b_reg     <= bus.in_b;
          carry_reg <= bus.in_c;
          idx_reg   <= '0;
        end
        RUN: begin
          carry_reg <= cla_cout;
          for (int k = 0; k < NUM_LIMBS; k++) begin
            if (idx_reg == IDX_W'(k)) sum_reg[k*LIMB_WIDTH +: LIMB_WIDTH] <= limb_sum;
          end
          if (last_limb) begin
            out_c_reg <= cla_cout;
            idx_reg   <= '0;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state_reg == RUN) assert (cla_cout == ripple[LIMB_WIDTH]);
  end
endmodule

// File: tb/tb_mp_adder_limb_seq.sv
// Self-checking bench for mp_adder_limb_seq: directed vector table, multi-cycle
// corner sequences and a randomized regression against a full-width sum model.
module tb_mp_adder_limb_seq;
  localparam int W  = 256;
  localparam int NL = W / 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mp_adder_limb_seq_if #(.ADDER_WIDTH(W)) bus ();

  mp_adder_limb_seq #(.ADDER_WIDTH(W), .LIMB_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string          name;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           c;
    logic [W-1:0]   es;
    logic           ec;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Random operand with some limbs forced to all-ones so long carry chains occur.
  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom;
    for (int k = 0; k < NL; k++) if ($urandom_range(0, 3) == 0) r[16*k +: 16] = 16'hFFFF;
    return r;
  endfunction

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                    input bit early, input int stall,
                    output logic [W-1:0] s, output logic co, output int lat);
    int guard;
    s = '0; co = 1'b0; lat = -1;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_c = c;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = rand_wide(); bus.in_b = rand_wide(); bus.in_c = 1'($urandom);
    bus.out_ready = early;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      chk("done_timeout", 0, 1);
      bus.out_ready = 1'b0;
      return;
    end
    repeat (stall) @(negedge clk);
    s  = bus.out_sum;
    co = bus.out_c;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", W'(bus.out_valid), 0);
    chk("ready_back", W'(bus.in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s, s0, ta, tb;
    logic [W:0]   ref_sum;
    logic         co, c0, tc;
    int           lat;

    vecs[0] = '{"ripple",   {W{1'b1}}, '0, 1'b1, '0, 1'b1};
    vecs[1] = '{"mixed",    256'h1_FFFF, 256'h1, 1'b0, 256'h2_0000, 1'b0};
    vecs[2] = '{"msb_limb", {NL{16'h8000}}, {NL{16'h8000}}, 1'b0,
                {{(NL-1){16'h0001}}, 16'h0000}, 1'b1};
    vecs[3] = '{"zero",     '0, '0, 1'b0, '0, 1'b0};
    vecs[4] = '{"ones_x2",  {W{1'b1}}, {W{1'b1}}, 1'b1, {W{1'b1}}, 1'b1};
    vecs[5] = '{"top_ovf",  {16'h8000, {(W-16){1'b0}}}, {16'h8000, {(W-16){1'b0}}},
                1'b1, 256'h1, 1'b1};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = 1'b0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(bus.out_valid), 0);
    chk("rst_out_sum",   {1'b0, bus.out_sum}, 0);
    chk("rst_out_c",     W'(bus.out_c), 0);
    chk("rst_busy",      W'(bus.busy), 0);
    chk("rst_in_ready",  W'(bus.in_ready), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].c, bit'(i % 2), 0, s, co, lat);
      chk({vecs[i].name, "_sum"}, {1'b0, s}, {1'b0, vecs[i].es});
      chk({vecs[i].name, "_c"},   W'(co), W'(vecs[i].ec));
      chk({vecs[i].name, "_lat"}, W'(lat), W'(NL));
      $display("vec %s: sum=%h c=%0d lat=%0d", vecs[i].name, s, co, lat);
    end

    // Backpressure: result must stay frozen while the consumer stalls.
    ta = rand_wide(); tb = rand_wide(); tc = 1'b1;
    ref_sum = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
    @(negedge clk);
    bus.in_a = ta; bus.in_b = tb; bus.in_c = tc; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", W'(lat), W'(NL));
    s0 = bus.out_sum; c0 = bus.out_c;
    chk("bp_sum", {1'b0, s0}, {1'b0, ref_sum[W-1:0]});
    chk("bp_c",   W'(c0), W'(ref_sum[W]));
    for (int i = 0; i < 5; i++) begin
      bus.in_a = rand_wide(); bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      chk("bp_hold_sum",   {1'b0, bus.out_sum}, {1'b0, s0});
      chk("bp_hold_c",     W'(bus.out_c), W'(c0));
      chk("bp_in_ready",   W'(bus.in_ready), 0);
      chk("bp_out_valid",  W'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_valid", W'(bus.out_valid), 0);
    chk("bp_release_ready", W'(bus.in_ready), 1);
    $display("backpressure: sum=%h c=%0d", s0, c0);

    // Reset while limb 7 is being processed.
    @(negedge clk);
    bus.in_a = rand_wide(); bus.in_b = rand_wide(); bus.in_c = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", W'(bus.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_out_valid", W'(bus.out_valid), 0);
    chk("mid_out_sum",   {1'b0, bus.out_sum}, 0);
    chk("mid_out_c",     W'(bus.out_c), 0);
    chk("mid_busy_low",  W'(bus.busy), 0);
    chk("mid_in_ready",  W'(bus.in_ready), 1);
    op(256'h1, 256'h1, 1'b0, 1'b0, 0, s, co, lat);
    chk("post_rst_sum", {1'b0, s}, 257'h2);
    chk("post_rst_c",   W'(co), 0);
    $display("reset mid-run then 1+1: sum=%h c=%0d", s, co);

    for (int n = 0; n < 1000; n++) begin
      bit early;
      int stall;
      ta = rand_wide(); tb = rand_wide(); tc = 1'($urandom_range(0, 1));
      early = ($urandom_range(0, 3) == 0);
      stall = early ? 0 : int'($urandom_range(0, 3));
      ref_sum = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
      op(ta, tb, tc, early, stall, s, co, lat);
      chk("rand_sum", {1'b0, s}, {1'b0, ref_sum[W-1:0]});
      chk("rand_c",   W'(co), W'(ref_sum[W]));
      chk("rand_lat", W'(lat), W'(NL));
      $display("rand %0d: c_in=%0d stall=%0d early=%0d sum=%h c=%0d", n, tc, stall, early, s, co);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
